fetch_bp: RTL and testbench
===========================

Name: fetch_bp

Overview:
- Parametrised next-generation IF stage: holds the PC, drives the instruction-memory address and packs the F/D pipeline bundle.
- Adds dynamic branch prediction: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters per entry.
- Sits between instruction memory and the F/D pipeline register. Decode/execute supplies branch resolution and mispredict redirect.

Parameters:
- DATA_W, 16, PC/instruction width in bits.
- BTB_ENTRIES, 8, BTB entry count; power of two, >= 2.
- PC_INC, 2, sequential PC increment in bytes; power of two.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hazard stall; hold PC.
- halt  in  1  halt from writeback; hold PC.
- mispredict  in  1  prediction was wrong; redirect fetch.
- redirect_pc  in  DATA_W  correct next PC when mispredict=1.
- resolve_valid  in  1  a branch resolved this cycle; update BTB.
- resolve_pc  in  DATA_W  address of the resolved branch.
- resolve_taken  in  1  actual branch direction.
- resolve_target  in  DATA_W  actual branch target.
- imem_addr  out  DATA_W  instruction-memory address; equals pc.
- imem_instr  in  DATA_W  instruction returned combinationally for imem_addr.
- pc  out  DATA_W  current PC.
- F_out  out  3*DATA_W+1  {pred_taken, pc, pc_plus, instr}, MSB first.

Behaviour:
- Derived widths: IDX_W = log2(BTB_ENTRIES); OFF_W = log2(PC_INC).
- Address fields: index = pc[OFF_W+IDX_W-1:OFF_W]; tag = pc[DATA_W-1:OFF_W+IDX_W].
- BTB entry contents: valid (1), tag, target (DATA_W), ctr (2).
- pc_plus = pc + PC_INC, mod 2^DATA_W; wraps silently, e.g. 16'hFFFE + 2 = 16'h0000.
- Lookup is combinational on the current pc:
  - hit = valid[index] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = target[index].
- Next-PC priority, registered on clk:
  1. rst: pc <= RESET_PC.
  2. mispredict: pc <= redirect_pc. Overrides stall and halt (the branch shadow must drain).
  3. halt: hold.
  4. stall: hold.
  5. pred_taken: pc <= pred_target.
  6. Otherwise: pc <= pc_plus.
- F_out is combinational from the current pc, imem_instr and the lookup. Zero added latency; the F/D register is external. While stalled, F_out stays constant.
- BTB update on resolve_valid, at the clock edge, indexed and tagged by resolve_pc:
  - Hit, taken: ctr saturating +1 (max 3); target <= resolve_target.
  - Hit, not taken: ctr saturating -1 (min 0); target unchanged.
  - Miss, taken: allocate. valid=1, tag written, target=resolve_target, ctr=2'b10 (weakly taken). Overwrites any aliasing entry.
  - Miss, not taken: no change.
- BTB updates are independent of stall, halt and mispredict.
- Same-cycle lookup and update to the same index: lookup sees the pre-update state (read-before-write).
- Reset:
  - All valid=0; all ctr=2'b01; targets and tags don't-care.
  - pc=RESET_PC, so the first cycle after reset gives imem_addr=RESET_PC and pred_taken=0.
  - Reset asserted mid-operation discards any pending update that edge; reset wins over resolve_valid.
- The block never checks imem_instr contents. No X propagation from the BTB after reset: valid=0 gates tag and target.

Test Plan:
- Reset, no branches, DATA_W=16 → pc sequence 0,2,4,6; F_out[48]=0; pc_plus=pc+2; wraps FFFE→0000.
- resolve_valid with resolve_pc=0x0004, taken, target=0x0040 → on next pass through 0x0004, pred_taken=1 and next pc=0x0040.
- Hysteresis: after the allocate above (ctr=10), one not-taken resolve → ctr=01, predicts not-taken. Two taken resolves → ctr=11. One not-taken → still predicts taken.
- mispredict=1 with redirect_pc=0x0100 while stall=1 and halt=1 → pc=0x0100 next cycle. Following cycle, with stall=1 only → pc holds 0x0100.
- Aliasing, 8 entries: allocate at 0x0004 (target 0x0040), then fetch 0x0014 (same index, different tag) → pred_taken=0, pc goes to 0x0016. Taken resolve at 0x0014 with target 0x0080 → next fetch of 0x0004 misses.
- rst asserted together with resolve_valid, after the BTB was populated → pc=RESET_PC and all entries invalid; the previously trained branch no longer predicts taken.

Source files
------------

// File: rtl/fetch_bp.sv
// Fetch stage with BTB-based dynamic branch prediction.
// Holds the PC, drives the instruction-memory address and packs the F/D bundle
// {pred_taken, pc, pc_plus, instr}. A direct-mapped BTB with 2-bit saturating
// counters predicts taken branches; decode/execute trains it via resolve_*.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   stall, halt             : hold the PC
//   mispredict, redirect_pc : redirect fetch (overrides stall/halt)
//   resolve_*               : branch resolution feedback for BTB training
//   imem_addr, imem_instr   : instruction-memory address / returned instruction
//   pc                      : current PC
//   F_out                   : combinational F/D bundle for the current PC
module fetch_bp #(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       BTB_ENTRIES = 8,
  parameter int unsigned       PC_INC      = 2,
  parameter logic [DATA_W-1:0] RESET_PC    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                halt,
  input  logic                mispredict,
  input  logic [DATA_W-1:0]   redirect_pc,
  input  logic                resolve_valid,
  input  logic [DATA_W-1:0]   resolve_pc,
  input  logic                resolve_taken,
  input  logic [DATA_W-1:0]   resolve_target,
  output logic [DATA_W-1:0]   imem_addr,
  input  logic [DATA_W-1:0]   imem_instr,
  output logic [DATA_W-1:0]   pc,
  output logic [3*DATA_W:0]   F_out
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned OFF_W = $clog2(PC_INC);
  localparam int unsigned TAG_W = DATA_W - OFF_W - IDX_W;

  logic [BTB_ENTRIES-1:0] valid;
  logic [1:0]             ctr    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag    [BTB_ENTRIES];
  logic [DATA_W-1:0]      target [BTB_ENTRIES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  ptag;
  logic [IDX_W-1:0]  ridx;
  logic [TAG_W-1:0]  rtag;
  logic              hit;
  logic              upd_hit;
  logic              pred_taken;
  logic [DATA_W-1:0] pred_target;
  logic [DATA_W-1:0] pc_plus;
  logic [DATA_W-1:0] pc_next_c;
  logic              unused_rpc_lsb;

  // Offset bits of resolve_pc select nothing in the BTB.
  assign unused_rpc_lsb = ^resolve_pc;

  // Combinational lookup on the current PC; valid gates tag/target.
  assign idx         = pc[OFF_W +: IDX_W];
  assign ptag        = pc[OFF_W+IDX_W +: TAG_W];
  assign hit         = valid[idx] && (tag[idx] == ptag);
  assign pred_taken  = hit && ctr[idx][1];
  assign pred_target = target[idx];
  assign pc_plus     = pc + DATA_W'(PC_INC);

  assign ridx    = resolve_pc[OFF_W +: IDX_W];
  assign rtag    = resolve_pc[OFF_W+IDX_W +: TAG_W];
  assign upd_hit = valid[ridx] && (tag[ridx] == rtag);

  assign imem_addr = pc;
  assign F_out     = {pred_taken, pc, pc_plus, imem_instr};

  // Next-PC priority: mispredict beats halt/stall, then prediction, then sequential.
  always_comb begin
    pc_next_c = pc_plus;
    if (mispredict)        pc_next_c = redirect_pc;
    else if (halt || stall) pc_next_c = pc;
    else if (pred_taken)   pc_next_c = pred_target;
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next_c;
  end

  // BTB valid bits and direction counters; reset discards a same-edge update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < int'(BTB_ENTRIES); i++) ctr[i] <= 2'b01;
    end else if (resolve_valid) begin
      if (upd_hit) begin
        if (resolve_taken) ctr[ridx] <= (ctr[ridx] == 2'b11) ? 2'b11 : ctr[ridx] + 2'd1;
        else               ctr[ridx] <= (ctr[ridx] == 2'b00) ? 2'b00 : ctr[ridx] - 2'd1;
      end else if (resolve_taken) begin
        valid[ridx] <= 1'b1;
        ctr[ridx]   <= 2'b10;
      end
    end
  end

  // Tag/target payload: written on any taken resolve (tag is unchanged on a hit).
  always_ff @(posedge clk) begin
    if (!rst && resolve_valid && resolve_taken) begin
      tag[ridx]    <= rtag;
      target[ridx] <= resolve_target;
    end
  end

endmodule

// File: tb/tb_fetch_bp.sv
// Directed table-driven bench for fetch_bp (DATA_W=16, 8 entries, PC_INC=2).
module tb_fetch_bp;

  logic        clk = 1'b0;
  logic        rst, stall, halt, mispredict, resolve_valid, resolve_taken;
  logic [15:0] redirect_pc, resolve_pc, resolve_target;
  logic [15:0] imem_addr, imem_instr, pc;
  logic [48:0] F_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instruction memory model: a fixed scramble of the address.
  assign imem_instr = imem_addr ^ 16'hA5A5;

  fetch_bp dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .pc(pc), .F_out(F_out)
  );

  typedef struct {
    logic [3:0]  ctl;   // {rst, stall, halt, mispredict}
    logic [15:0] rd;
    logic        rv;
    logic        rtk;
    logic [15:0] rpc;
    logic [15:0] rtgt;
    logic [15:0] epc;   // expected pc before the edge
    logic        epred; // expected pred_taken before the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [15:0] epc, input logic epred,
                              input logic [3:0] ctl, input logic [15:0] rd,
                              input logic rv, input logic rtk,
                              input logic [15:0] rpc, input logic [15:0] rtgt);
    vec_t v;
    v.ctl = ctl; v.rd = rd; v.rv = rv; v.rtk = rtk; v.rpc = rpc; v.rtgt = rtgt;
    v.epc = epc; v.epred = epred;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [48:0] act, input logic [48:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    {rst, stall, halt, mispredict} = v.ctl;
    redirect_pc    = v.rd;
    resolve_valid  = v.rv;
    resolve_taken  = v.rtk;
    resolve_pc     = v.rpc;
    resolve_target = v.rtgt;
  endtask

  task automatic check(input string tag, input logic [15:0] epc, input logic epred);
    logic [15:0] eplus;
    eplus = epc + 16'd2;
    cmp({tag, " pc"}, 49'(pc), 49'(epc));
    cmp({tag, " imem_addr"}, 49'(imem_addr), 49'(epc));
    cmp({tag, " F_out"}, F_out, {epred, epc, eplus, epc ^ 16'hA5A5});
  endtask

  initial begin
    // Table: inputs held for one cycle; expectations are pre-edge.
    vecs.push_back(mk(16'h0000, 0, 4'b0000, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0002, 0, 4'b0000, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 0, 4'b0000, 16'h0000, 1, 1, 16'h0004, 16'h0040)); // allocate
    vecs.push_back(mk(16'h0006, 0, 4'b0001, 16'h0004, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 1, 4'b0000, 16'h0000, 0, 0, 16'h0000, 16'h0000)); // predict taken
    vecs.push_back(mk(16'h0040, 0, 4'b0001, 16'h0004, 1, 0, 16'h0004, 16'h0000)); // ctr 10->01
    vecs.push_back(mk(16'h0004, 0, 4'b0000, 16'h0000, 1, 1, 16'h0004, 16'h0040)); // read-before-write
    vecs.push_back(mk(16'h0006, 0, 4'b0001, 16'h0004, 1, 1, 16'h0004, 16'h0060)); // ctr 11, new target
    vecs.push_back(mk(16'h0004, 1, 4'b0000, 16'h0000, 1, 0, 16'h0004, 16'h0000)); // ctr 11->10
    vecs.push_back(mk(16'h0060, 0, 4'b0001, 16'h0004, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 1, 4'b0100, 16'h0000, 0, 0, 16'h0000, 16'h0000)); // stall
    vecs.push_back(mk(16'h0004, 1, 4'b0010, 16'h0000, 0, 0, 16'h0000, 16'h0000)); // halt
    vecs.push_back(mk(16'h0004, 1, 4'b0111, 16'h0100, 0, 0, 16'h0000, 16'h0000)); // mispredict wins
    vecs.push_back(mk(16'h0100, 0, 4'b0100, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0100, 0, 4'b0000, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0102, 0, 4'b0001, 16'h0014, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0014, 0, 4'b0000, 16'h0000, 1, 1, 16'h0014, 16'h0080)); // alias miss, realloc
    vecs.push_back(mk(16'h0016, 0, 4'b0001, 16'h0004, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0004, 0, 4'b0000, 16'h0000, 0, 0, 16'h0000, 16'h0000)); // evicted
    vecs.push_back(mk(16'h0006, 0, 4'b0001, 16'h0014, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0014, 1, 4'b0000, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'h0080, 0, 4'b0001, 16'hFFFC, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'hFFFC, 0, 4'b0000, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(16'hFFFE, 0, 4'b0000, 16'h0000, 0, 0, 16'h0000, 16'h0000)); // wrap
    vecs.push_back(mk(16'h0000, 0, 4'b1000, 16'h0000, 1, 1, 16'h0014, 16'h0200)); // rst beats update
    vecs.push_back(mk(16'h0000, 0, 4'b0001, 16'h0014, 1, 0, 16'h0014, 16'h0000)); // miss+not-taken
    vecs.push_back(mk(16'h0014, 0, 4'b0000, 16'h0000, 0, 0, 16'h0000, 16'h0000)); // cleared by reset
    vecs.push_back(mk(16'h0016, 0, 4'b0000, 16'h0000, 0, 0, 16'h0000, 16'h0000));

    rst = 1'b1; stall = 1'b0; halt = 1'b0; mispredict = 1'b0; redirect_pc = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_pc = '0; resolve_target = '0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].epred);
      @(negedge clk);
    end

    // Sustained stall: PC and bundle frozen for several cycles, then resume.
    apply(mk(16'h0, 0, 4'b0100, 16'h0, 0, 0, 16'h0, 16'h0));
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d", k), 16'h0018, 1'b0);
      @(negedge clk);
    end
    apply(mk(16'h0, 0, 4'b0000, 16'h0, 0, 0, 16'h0, 16'h0));
    #1;
    check("resume", 16'h0018, 1'b0);
    @(negedge clk);
    #1;
    check("resume_next", 16'h001A, 1'b0);

    // Halt with a taken resolve: BTB trains while the PC holds.
    apply(mk(16'h0, 0, 4'b0010, 16'h0, 1, 1, 16'h001A, 16'h0300));
    @(negedge clk);
    apply(mk(16'h0, 0, 4'b0000, 16'h0, 0, 0, 16'h0, 16'h0));
    #1;
    check("halt_train", 16'h001A, 1'b1);
    @(negedge clk);
    #1;
    check("halt_redirect", 16'h0300, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
